display_7seg_mux: RTL and testbench

//  Consumer of the matrix keypad scanner's key codes. Keeps the last N_DIGITS keys entered
//  in a shift register and shows them on the board's multiplexed 4-digit 7-segment display.
//  '*' clears the entry and '#' deletes the last digit. Sits between the keypad scanner
//  (key_valid/key_code) and the anodo_po/catodo_po pins in the keypad top level.

---
 rtl/teclado_pkg.sv | 15 +
 rtl/seg7_decoder.sv | 35 +++
 rtl/display_7seg_mux.sv | 91 +++++++++
 tb/tb_display_7seg_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// teclado_pkg: key codes, segment constants and types shared by the keypad blocks.
// Revision: 1.0
`default_nettype none

package teclado_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t  KEY_STAR = 4'hE;
  localparam key_code_t  KEY_HASH = 4'hF;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// seg7_decoder: key code to active-low {g,f,e,d,c,b,a} segments; '*'/'#' render dark.
// Revision: 1.0
`default_nettype none

module seg7_decoder
  import teclado_pkg::*;
(
  input  key_code_t   code,
  output logic [6:0]  seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_7seg_mux.sv
// display_7seg_mux: keypad entry shift register driving a multiplexed 7-segment display.
// Revision: 1.0
`default_nettype none

module display_7seg_mux
  import teclado_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DIGIT_TICKS = 6750,
  parameter int BLANK_EMPTY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [2:0]          entry_cnt,
  output logic [N_DIGITS-1:0] anodo_po,
  output logic [6:0]          catodo_po
);

  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [2:0]          CNT_MAX  = 3'(N_DIGITS);
  localparam logic [CW-1:0]       SLOT_MAX = CW'(DIGIT_TICKS - 1);
  localparam logic [SW-1:0]       SEL_MAX  = SW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};

  key_code_t     digit [N_DIGITS];
  logic [CW-1:0] slot_cnt;
  logic [SW-1:0] digit_sel;
  logic [6:0]    seg;
  logic          blank;

  seg7_decoder u_dec (
    .code (digit[digit_sel]),
    .seg  (seg)
  );

  // Entry register: digit[0] is the rightmost (most recent) position.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) digit[i] <= '0;
      entry_cnt <= '0;
    end else if (key_valid) begin
      if (key_code == KEY_STAR) begin
        for (int i = 0; i < N_DIGITS; i++) digit[i] <= '0;
        entry_cnt <= '0;
      end else if (key_code == KEY_HASH) begin
        if (entry_cnt != 3'd0) begin
          for (int i = 0; i < N_DIGITS - 1; i++) digit[i] <= digit[i+1];
          digit[N_DIGITS-1] <= '0;
          entry_cnt <= entry_cnt - 3'd1;
        end
      end else begin
        for (int i = 1; i < N_DIGITS; i++) digit[i] <= digit[i-1];
        digit[0] <= key_code;
        if (entry_cnt < CNT_MAX) entry_cnt <= entry_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_sel <= '0;
    end else if (slot_cnt == SLOT_MAX) begin
      slot_cnt  <= '0;
      digit_sel <= (digit_sel == SEL_MAX) ? '0 : digit_sel + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign blank = (BLANK_EMPTY != 0) && ({1'b0, 3'(digit_sel)} >= {1'b0, entry_cnt});

  always_ff @(posedge clk) begin
    if (rst) begin
      anodo_po  <= '1;
      catodo_po <= SEG_OFF;
    end else if (blank) begin
      anodo_po  <= '1;
      catodo_po <= SEG_OFF;
    end else begin
      anodo_po  <= ~(AN_ONE << digit_sel);
      catodo_po <= seg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_7seg_mux.sv
// tb_display_7seg_mux: scoreboard bench; stimulus queues expected slot contents, a monitor checks each slot visit.
// Revision: 1.0
`default_nettype none

module tb_display_7seg_mux;

  localparam int TICKS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [2:0] entry_cnt;
  logic [3:0] anodo_po;
  logic [6:0] catodo_po;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  typedef struct {
    int         slot;
    logic [3:0] an;
    logic [6:0] cat;
    logic [2:0] cnt;
    int         earliest;
  } exp_t;

  exp_t q[$];

  display_7seg_mux #(
    .N_DIGITS    (4),
    .DIGIT_TICKS (TICKS),
    .BLANK_EMPTY (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry_cnt (entry_cnt),
    .anodo_po  (anodo_po),
    .catodo_po (catodo_po)
  );

  always #5 clk = ~clk;

  // Edges since reset release; output after edge k shows slot ((k-1)/TICKS) mod 4.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  initial begin : monitor
    exp_t e;
    int   cur;
    forever begin
      @(negedge clk);
      if (!rst && k >= 1 && ((k - 1) % TICKS) == TICKS / 2 && q.size() > 0) begin
        cur = ((k - 1) / TICKS) % 4;
        if (q[0].slot == cur && k >= q[0].earliest) begin
          e = q.pop_front();
          vectors++;
          if (anodo_po !== e.an || catodo_po !== e.cat || entry_cnt !== e.cnt) begin
            miscompares++;
            $display("FAIL slot%0d: got an=%h cat=%h cnt=%0d, want an=%h cat=%h cnt=%0d",
                     cur, anodo_po, catodo_po, entry_cnt, e.an, e.cat, e.cnt);
          end
        end
      end
    end
  end

  task automatic push_exp(input int slot, input bit lit, input logic [6:0] cat, input logic [2:0] cnt);
    exp_t       e;
    logic [3:0] one;
    one = 4'b0001;
    e.slot     = slot;
    e.an       = lit ? ~(one << slot) : 4'hF;
    e.cat      = lit ? cat : 7'h7F;
    e.cnt      = cnt;
    e.earliest = k + 2;
    q.push_back(e);
  endtask

  task automatic push_blanks(input int from, input logic [2:0] cnt);
    for (int s = from; s < 4; s++) push_exp(s, 1'b0, 7'h7F, cnt);
  endtask

  task automatic send_key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, got %0d pending slot checks, want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_direct(input string name, input logic [3:0] an, input logic [6:0] cat,
                              input logic [2:0] cnt);
    vectors++;
    if (anodo_po !== an || catodo_po !== cat || entry_cnt !== cnt) begin
      miscompares++;
      $display("FAIL %s: got an=%h cat=%h cnt=%0d, want an=%h cat=%h cnt=%0d",
               name, anodo_po, catodo_po, entry_cnt, an, cat, cnt);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no end of stimulus, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // 1: reset state, then two blank frames
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_direct("reset", 4'hF, 7'h7F, 3'd0);
    rst = 1'b0;
    push_blanks(0, 3'd0);
    push_blanks(0, 3'd0);
    drain("t1");

    // 2: three digits
    send_key(4'h1); send_key(4'h2); send_key(4'h3);
    push_exp(0, 1'b1, 7'h30, 3'd3);
    push_exp(1, 1'b1, 7'h24, 3'd3);
    push_exp(2, 1'b1, 7'h79, 3'd3);
    push_blanks(3, 3'd3);
    drain("t2");

    // 3: saturation drops the oldest digit
    send_key(4'hE);
    for (int d = 1; d <= 5; d++) send_key(4'(d));
    push_exp(0, 1'b1, 7'h12, 3'd4);
    push_exp(1, 1'b1, 7'h19, 3'd4);
    push_exp(2, 1'b1, 7'h30, 3'd4);
    push_exp(3, 1'b1, 7'h24, 3'd4);
    drain("t3");

    // 4: delete, clear, delete on empty
    send_key(4'hF);
    push_exp(0, 1'b1, 7'h19, 3'd3);
    push_exp(1, 1'b1, 7'h30, 3'd3);
    push_exp(2, 1'b1, 7'h24, 3'd3);
    push_blanks(3, 3'd3);
    drain("t4a");
    send_key(4'hE);
    push_blanks(0, 3'd0);
    drain("t4b");
    send_key(4'hF);
    check_direct("hash_empty", anodo_po, catodo_po, 3'd0);
    push_blanks(0, 3'd0);
    drain("t4c");

    // 5: key accepted on the slot-wrap edge
    for (int i = 0; i < 2 * TICKS && (k % TICKS) != TICKS - 1; i++) @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'h7;
    @(negedge clk);
    key_valid = 1'b0;
    push_exp(0, 1'b1, 7'h78, 3'd1);
    push_blanks(1, 3'd1);
    drain("t5a");
    send_key(4'hA);
    push_exp(0, 1'b1, 7'h08, 3'd2);
    push_exp(1, 1'b1, 7'h78, 3'd2);
    push_blanks(2, 3'd2);
    drain("t5b");

    // 6: reset mid-frame with two digits stored
    send_key(4'hE); send_key(4'h1); send_key(4'h2);
    push_exp(0, 1'b1, 7'h24, 3'd2);
    push_exp(1, 1'b1, 7'h79, 3'd2);
    drain("t6a");
    repeat (TICKS + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_direct("mid_reset", 4'hF, 7'h7F, 3'd0);
    rst = 1'b0;
    send_key(4'h9);
    push_exp(0, 1'b1, 7'h10, 3'd1);
    push_blanks(1, 3'd1);
    drain("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
